result_display_ctrl: RTL and testbench

Parametrised successor to the single-digit class display. It latches each CNN result on the rising edge of finish and keeps a decimal inference count with leading-zero blanking across the remaining digits. Digit 0 shows the class, blinks while an inference is in flight, and shows an error glyph on timeout. The block sits between cnn_top and the board HEX/LED pins inside fpga_top.

---
 rtl/display_pkg.sv | 40 ++++
 rtl/result_display_ctrl_bcd_counter.sv | 45 ++++
 rtl/result_display_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_result_display_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the result display.
// Ports: none (package). Holds the FSM state encoding, segment constants
// and the board's active-low {g,f,e,d,c,b,a} hex glyph table.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_SHOW = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/result_display_ctrl_bcd_counter.sv
// Multi-digit BCD counter with decimal carry; all-9s wraps to all-0s.
// Ports: clk, reset (async, active-high), clr (sync, wins over inc),
// inc (add one this cycle), bcd (registered, digit i at [4i+3:4i]).
module bcd_counter #(
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_d;
  logic                carry;

  // Ripple a carry up from digit 0; a 9 rolls to 0 and passes the carry on.
  always_comb begin
    bcd_d = bcd_q;
    carry = inc;
    if (clr) begin
      bcd_d = '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/result_display_ctrl.sv
// CNN result display: latches class on finish, counts inferences in BCD,
// blinks digit 0 while busy, shows 'E' on timeout.
// Ports: clk, reset (async high), start (async switch), finish/class_in,
// clear (sync); outputs hex (7 bits/digit, active-low), busy, result_valid,
// error, class_out. All outputs registered; hex lags state by one edge.
module result_display_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int CLASS_W     = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int BLINK_HZ    = 2,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int LZB         = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    finish,
  input  logic [CLASS_W-1:0]      class_in,
  input  logic                    clear,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    busy,
  output logic                    result_valid,
  output logic                    error,
  output logic [3:0]              class_out
);

  localparam int CNT_DIGITS = NUM_DIGITS - 1;
  localparam int HALF       = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW         = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(HALF - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  // start synchroniser + edge register, finish edge register
  logic start_s1_q, start_s2_q, start_s3_q;
  logic finish_q;
  logic start_rise, finish_rise, timeout_hit;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  phase_q, phase_d;
  logic [3:0]            class_q, class_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  logic                  cnt_clr, cnt_inc;
  logic [4*CNT_DIGITS-1:0] count_bcd;

  assign start_rise  = start_s2_q & ~start_s3_q;
  assign finish_rise = finish & ~finish_q;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST);

  bcd_counter #(.DIGITS(CNT_DIGITS)) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .bcd   (count_bcd)
  );

  // Next-state: clear > finish_rise > timeout > start_rise
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    presc_d = presc_q;
    phase_d = phase_q;
    class_d = class_q;
    valid_d = valid_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      valid_d = 1'b0;
      class_d = 4'd0;
      timer_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          timer_d = timer_q + 1'b1;
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (finish_rise) begin
            class_d = 4'(class_in);
            valid_d = 1'b1;
            cnt_inc = 1'b1;
            state_d = ST_SHOW;
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end
        end
        default: begin
          // IDLE, SHOW and ERR all re-arm on start; finish is ignored here.
          if (start_rise) begin
            state_d = ST_BUSY;
            timer_d = '0;
            presc_d = '0;
            phase_d = 1'b1;
          end
        end
      endcase
    end
    busy_d  = (state_d == ST_BUSY);
    error_d = (state_d == ST_ERR);
  end

  // Display image built from the current registered state, so it lands one
  // edge after the state/count it reflects.
  logic       seen_nz;
  logic [3:0] digit;
  always_comb begin
    hex_d   = '1;
    seen_nz = 1'b0;
    digit   = 4'd0;
    case (state_q)
      ST_IDLE: hex_d[6:0] = SEG_DASH;
      ST_BUSY: hex_d[6:0] = phase_q ? (valid_q ? hex_to_seg(class_q) : SEG_DASH)
                                    : SEG_BLANK;
      ST_SHOW: hex_d[6:0] = hex_to_seg(class_q);
      default: hex_d[6:0] = SEG_E;
    endcase
    // Scan from the most significant count digit down; blank until the
    // first non-zero digit, but never blank the units digit.
    for (int j = CNT_DIGITS - 1; j >= 0; j--) begin
      digit = count_bcd[4*j +: 4];
      if (digit != 4'd0) seen_nz = 1'b1;
      if ((LZB != 0) && !seen_nz && (j != 0))
        hex_d[7*(j+1) +: 7] = SEG_BLANK;
      else
        hex_d[7*(j+1) +: 7] = hex_to_seg(digit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
      finish_q   <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      presc_q    <= '0;
      phase_q    <= 1'b1;
      class_q    <= 4'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      hex_q      <= '1;
    end else begin
      start_s1_q <= start;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      finish_q   <= finish;
      state_q    <= state_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      class_q    <= class_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      hex_q      <= hex_d;
    end
  end

  assign hex          = hex_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign result_valid = valid_q;
  assign class_out    = class_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Self-checking bench for result_display_ctrl: directed scenarios plus random
// start/finish/clear traffic, compared every cycle against a behavioural model.
// Ports: none (top-level bench).
module tb_result_display_ctrl;

  localparam int ND   = 4;
  localparam int HALF = 4;
  localparam int TO   = 20;
  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                           7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset, start, finish, clear;
  logic [3:0]  class_in;
  logic [27:0] hex;
  logic        busy, result_valid, error;
  logic [3:0]  class_out;

  always #5 clk = ~clk;

  result_display_ctrl #(
    .NUM_DIGITS(ND), .CLASS_W(4), .CLK_HZ(8), .BLINK_HZ(1),
    .TIMEOUT_CYC(TO), .LZB(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .class_in(class_in), .clear(clear), .hex(hex), .busy(busy),
    .result_valid(result_valid), .error(error), .class_out(class_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_BUSY, M_SHOW, M_ERR} mstate_t;
  mstate_t     m_st;
  int          m_count;     // inference count, 0..999
  int          m_t;         // cycles spent in the current BUSY visit
  logic [3:0]  m_class;
  bit          m_rv;
  bit          h1, h2, h3;  // start samples from 1, 2, 3 edges ago
  bit          fprev;
  logic [27:0] m_hex;

  function automatic logic [27:0] model_hex();
    logic [6:0] d0, d1, d2, d3;
    case (m_st)
      M_IDLE:  d0 = 7'h3F;
      M_BUSY:  d0 = (((m_t / HALF) % 2) == 0) ? (m_rv ? SEG_TAB[m_class] : 7'h3F) : BLK;
      M_SHOW:  d0 = SEG_TAB[m_class];
      default: d0 = 7'h06;
    endcase
    d1 = SEG_TAB[m_count % 10];
    d2 = (m_count >= 10)  ? SEG_TAB[(m_count / 10) % 10] : BLK;
    d3 = (m_count >= 100) ? SEG_TAB[m_count / 100] : BLK;
    return {d3, d2, d1, d0};
  endfunction

  always @(posedge clk) begin
    bit srise, frise;
    if (reset) begin
      m_st = M_IDLE; m_count = 0; m_t = 0; m_class = 4'd0; m_rv = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; fprev = 1'b0;
      m_hex = {4{BLK}};
    end else begin
      m_hex = model_hex();
      srise = h2 && !h3;
      frise = finish && !fprev;
      h3 = h2; h2 = h1; h1 = start; fprev = finish;
      if (clear) begin
        m_st = M_IDLE; m_count = 0; m_rv = 1'b0; m_class = 4'd0; m_t = 0;
      end else if (m_st == M_BUSY) begin
        if (frise) begin
          m_class = class_in; m_rv = 1'b1; m_count = (m_count + 1) % 1000; m_st = M_SHOW;
        end else if (m_t == TO - 1) begin
          m_st = M_ERR;
        end else begin
          m_t++;
        end
      end else if (srise) begin
        m_st = M_BUSY; m_t = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check_eq("busy",         busy,         m_st == M_BUSY);
      check_eq("error",        error,        m_st == M_ERR);
      check_eq("result_valid", result_valid, m_rv);
      check_eq("class_out",    class_out,    m_class);
      check_eq("hex",          hex,          m_hex);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_inf(input logic [3:0] cls, input int gap);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (gap) @(negedge clk);
    finish = 1'b1; class_in = cls;
    @(negedge clk);
    finish = 1'b0; class_in = 4'($urandom);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; clear = 1'b0; class_in = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // 1: idle display after reset
    check_eq("t1_hex",   hex,  {7'h7F, 7'h7F, 7'h40, 7'h3F});
    check_eq("t1_busy",  busy, 1'b0);
    check_eq("t1_valid", result_valid, 1'b0);

    // 2: first inference, busy from the third edge
    start = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t2_busy_edge2", busy, 1'b0);
    @(negedge clk);
    check_eq("t2_busy_edge3", busy, 1'b1);
    start = 1'b0;
    repeat (7) @(negedge clk);
    finish = 1'b1; class_in = 4'd7;
    @(negedge clk);
    finish = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t2_valid", result_valid, 1'b1);
    check_eq("t2_class", class_out, 4'd7);
    check_eq("t2_dig0",  hex[6:0],  7'h78);
    check_eq("t2_dig1",  hex[13:7], 7'h79);

    // 3: twelve inferences of class B from a cleared count
    clear = 1'b1; @(negedge clk); clear = 1'b0; @(negedge clk);
    for (int i = 0; i < 12; i++) run_inf(4'hB, $urandom_range(0, 6));
    check_eq("t3_hex", hex, {7'h7F, 7'h79, 7'h24, 7'h03});

    // 4: timeout, then recover
    start = 1'b1; repeat (3) @(negedge clk); start = 1'b0;
    repeat (22) @(negedge clk);
    check_eq("t4_error", error, 1'b1);
    check_eq("t4_busy",  busy,  1'b0);
    check_eq("t4_dig0",  hex[6:0],  7'h06);
    check_eq("t4_count", hex[27:7], {7'h7F, 7'h79, 7'h24});
    start = 1'b1; repeat (3) @(negedge clk);
    check_eq("t4_rebusy", busy,  1'b1);
    check_eq("t4_noerr",  error, 1'b0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    finish = 1'b1; class_in = 4'd3; @(negedge clk); finish = 1'b0;
    repeat (2) @(negedge clk);

    // 5: finish on the last timer cycle wins over timeout; clear mid-busy
    start = 1'b1; repeat (3) @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    finish = 1'b1; class_in = 4'd5; @(negedge clk); finish = 1'b0;
    check_eq("t5_error", error, 1'b0);
    check_eq("t5_valid", result_valid, 1'b1);
    check_eq("t5_class", class_out, 4'd5);
    start = 1'b1; repeat (3) @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    check_eq("t5_clr_busy",  busy, 1'b0);
    check_eq("t5_clr_valid", result_valid, 1'b0);
    @(negedge clk);
    check_eq("t5_clr_count", hex[27:7], {7'h7F, 7'h7F, 7'h40});

    // 6: count to 999, wrap to 0, finish ignored in SHOW
    for (int i = 0; i < 999; i++) run_inf(4'($urandom_range(0, 15)), 0);
    check_eq("t6_999", hex[27:7], {7'h10, 7'h10, 7'h10});
    run_inf(4'd9, 1);
    check_eq("t6_wrap", hex[27:7], {7'h7F, 7'h7F, 7'h40});
    finish = 1'b1; class_in = 4'd2; @(negedge clk); finish = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_show_fin",   hex[27:7], {7'h7F, 7'h7F, 7'h40});
    check_eq("t6_show_class", class_out, 4'd9);

    // 7: random traffic, first with frequent finishes, then sparse (timeouts)
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) start = ~start;
      finish   = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      clear    = ($urandom_range(0, 80) == 0);
      class_in = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0; finish = 1'b0; clear = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
